// File: rtl/lc2k_lsu_pkg.sv
// Shared types and default parameters for the LC2K load/store initiator.
package lc2k_lsu_pkg;

    localparam int ADDR_W_DEF         = 6;
    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/lc2k_lsu_watchdog.sv
// Cycle counter that flags a stuck memory access; used only when LC2K_LSU_TIMEOUT_EN is defined.
module lc2k_lsu_watchdog
    import lc2k_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/lc2k_lsu.sv
// LC2K load/store initiator: one lw/sw at a time over a req/gnt/rvalid memory handshake.
// Optional watchdog enabled by defining LC2K_LSU_TIMEOUT_EN.
module lc2k_lsu
    import lc2k_lsu_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state;
    state_e            state_nx;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic range_bad;
    logic in_flight;
    logic complete;
    logic timeout;
    logic expire;

    assign range_bad = |cpu_addr[31:ADDR_W];
    assign in_flight = (state == ST_REQ) || (state == ST_WAIT);

    // A response only counts once the request has been granted.
    assign complete = ((state == ST_REQ) && mem_gnt && mem_rvalid) ||
                      ((state == ST_WAIT) && mem_rvalid);

`ifdef LC2K_LSU_TIMEOUT_EN
    lc2k_lsu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_IDLE),
        .enable (in_flight),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign expire = in_flight && timeout && !complete;

    // NOTE: assign a default first so no path through the case leaves state_nx unassigned (latch).
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cpu_valid) state_nx = range_bad ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (complete || expire) state_nx = ST_RESP;
                else if (mem_gnt)       state_nx = ST_WAIT;
            end
            ST_WAIT: if (complete || expire) state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && cpu_valid) begin
                we_q    <= cpu_write;
                addr_q  <= cpu_addr[ADDR_W-1:0];
                wdata_q <= cpu_wdata;
                rdata_q <= '0;
                err_q   <= range_bad;
            end else if (complete) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end else if (expire) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign mem_req   = (state == ST_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_done  = (state == ST_RESP);
    assign cpu_rdata = cpu_done ? rdata_q : '0;
    assign cpu_err   = cpu_done & err_q;
    assign cpu_stall = cpu_valid & ~cpu_done;

endmodule
